counting_gen: RTL and testbench
===============================

# counting_gen

Pattern generator that drives the 2-bit symbol stream consumed by the `1,2,3` sequence detector, the sending end of the same symbol interface. On a `start` request it emits `count` complete `1,2,3` patterns, optionally separated by idle symbols `0` that the detector ignores. It uses a ready/valid handshake on the symbol output, and reports `busy` and a one-cycle `done`. It is used as the stimulus source and loopback partner for the detector.

## Interface
- `CNT_W`, default 4: width of the pattern-count input and the internal remaining-pattern counter.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: synchronous active-low reset, sampled on rising `clk`.
- `start` input 1: request to begin a burst; sampled only in IDLE.
- `count` input CNT_W: number of `1,2,3` patterns to emit; latched with `start`.
- `gap` input 2: number of idle `0` symbols inserted between consecutive patterns; latched with `start`.
- `ready` input 1: downstream accepts the current symbol this cycle.
- `num` output 2: current symbol.
- `valid` output 1: `num` holds a symbol to be transferred.
- `busy` output 1: a burst is in progress.
- `done` output 1: one-cycle pulse after the last symbol of a burst is accepted.

## Operation
- Clock and reset: one clock. `rst_n` is synchronous and active-low. All outputs are registered.
- Reset values: `num`=0, `valid`=0, `busy`=0, `done`=0, state=IDLE, counters cleared.
- States: IDLE, SYM1, SYM2, SYM3, GAP.
- A transfer happens when `valid && ready` at a rising edge. Without a transfer, `num` and `valid` hold their values.
- IDLE:
  - `start`=1 with `count`>0: latch `count` into `remain` and `gap` into `gap_q`, go to SYM1.
  - `start`=1 with `count`=0: stay in IDLE and pulse `done` for one cycle. No symbol is emitted.
- SYM1: `num`=1, `valid`=1. On transfer, go to SYM2.
- SYM2: `num`=2, `valid`=1. On transfer, go to SYM3.
- SYM3: `num`=3, `valid`=1. On transfer, decrement `remain`, then:
  - `remain`=1 (this was the last pattern): go to IDLE and pulse `done`.
  - else if `gap_q`=0: go to SYM1.
  - else: load `gap_cnt`=`gap_q` and go to GAP.
- GAP: `num`=0, `valid`=1. On each transfer, decrement `gap_cnt`. On the transfer with `gap_cnt`=1, go to SYM1.
- `busy`=1 in every state except IDLE.
- `start` while busy is ignored. `count` and `gap` changes mid-burst have no effect.
- `remain` is CNT_W wide. The maximum burst is 2^CNT_W−1 patterns and no wrap is possible.
- Reset asserted mid-burst aborts it: the next cycle shows reset values and no `done` is produced.
- `ready` may be low at any point. There is no timeout.

## Timing
- `start` sampled at edge T (count>0): at T+1 `busy`=1, `valid`=1, `num`=1.
- Each accepted symbol is replaced by the next symbol at the following cycle. With `ready` held at 1, throughput is 1 symbol/cycle.
- Burst length with `ready`=1 is 3·N + gap·(N−1) cycles of `valid`.
- Last `3` accepted at edge K: at K+1 `valid`=0, `busy`=0, `num`=0, and `done`=1 for exactly one cycle.
- A `start` sampled at K+1 is accepted: `done` and the new burst's first symbol (`num`=1) overlap by zero cycles, so the first symbol appears at K+2.
- `count`=0 request at edge T: `done`=1 at T+1, and `busy` stays 0.
- Total latency from `start` to `done` with `ready`=1 is 3·N + gap·(N−1) + 1 cycles.

## Test plan
- Reset, then `start` with count=1, gap=0, `ready`=1 -> `num` sequence 1,2,3 on cycles T+1..T+3. `done`=1 at T+4 only; a detector fed the stream shows `ans`=1 once.
- count=3, gap=2, `ready`=1 -> `num` = 1,2,3,0,0,1,2,3,0,0,1,2,3 (13 valid cycles), then `done`. The detector's `ans` rises 3 times.
- count=2, gap=0, `ready` toggling 1,0,1,0… -> each symbol is held while `ready`=0. The stream is 1,2,3,1,2,3 with no loss or duplication, and `done` comes exactly 1 cycle after the final accepted `3`.
- `start` with count=0 -> `done`=1 one cycle later, `valid` never asserts, `busy` stays 0. A second `start` (count=5) pulsed mid-burst of an earlier count=2 burst is ignored, giving only 6 symbols.
- `rst_n`=0 asserted during SYM2 of a count=4 burst -> next cycle all outputs are 0 and there is no `done`. A new `start` afterward emits a full fresh burst beginning with `num`=1.
- CNT_W=4, count=15, gap=0, `ready`=1 -> 45 valid symbols, then a single `done`. `remain` does not wrap.

Source files
------------

// File: rtl/counting_gen.sv
// Symbol-stream source for the 1,2,3 sequence detector: emits `count` patterns
// of 1,2,3 separated by `gap` idle zeros, over a ready/valid handshake.
module counting_gen #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       gap,
  input  logic             ready,
  output logic [1:0]       num,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYM1 = 3'd1,
    SYM2 = 3'd2,
    SYM3 = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remain;
  logic [1:0]       gap_q;
  logic [1:0]       gap_cnt;
  logic             xfer;

  assign xfer = valid && ready;

  // All outputs are registered and set together with the next state, so the
  // symbol on `num` always matches the state that is holding it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      remain  <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      num     <= 2'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              remain <= count;
              gap_q  <= gap;
              state  <= SYM1;
              num    <= 2'd1;
              valid  <= 1'b1;
              busy   <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SYM1: begin
          if (xfer) begin
            state <= SYM2;
            num   <= 2'd2;
          end
        end
        SYM2: begin
          if (xfer) begin
            state <= SYM3;
            num   <= 2'd3;
          end
        end
        SYM3: begin
          if (xfer) begin
            remain <= remain - 1'b1;
            if (remain == CNT_W'(1)) begin
              state <= IDLE;
              num   <= 2'd0;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (gap_q == 2'd0) begin
              state <= SYM1;
              num   <= 2'd1;
            end else begin
              gap_cnt <= gap_q;
              state   <= GAP;
              num     <= 2'd0;
            end
          end
        end
        GAP: begin
          if (xfer) begin
            gap_cnt <= gap_cnt - 1'b1;
            if (gap_cnt == 2'd1) begin
              state <= SYM1;
              num   <= 2'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          num   <= 2'd0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counting_gen.sv
// Directed bench for counting_gen: expected symbols are queued when a burst is
// started and popped on every observed transfer.
module tb_counting_gen;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [1:0]       gap;
  logic             ready;
  logic [1:0]       num;
  logic             valid;
  logic             busy;
  logic             done;

  counting_gen #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .count (count),
    .gap   (gap),
    .ready (ready),
    .num   (num),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int sb[$];
  int valid_cyc, dones, done_ok, lat;
  bit prev_xfer;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference stream for one burst.
  task automatic push_burst(input int cnt, input int gp);
    for (int p = 0; p < cnt; p++) begin
      sb.push_back(1);
      sb.push_back(2);
      sb.push_back(3);
      if (p < cnt - 1)
        for (int g = 0; g < gp; g++) sb.push_back(0);
    end
  endtask

  // Called at a falling edge: observe outputs, drive ready for the next
  // rising edge, score any transfer, then advance to the next falling edge.
  task automatic tick(input bit rdy);
    int e;
    ready = rdy;
    if (valid) valid_cyc++;
    if (done) begin
      dones++;
      if (prev_xfer && sb.size() == 0) done_ok++;
    end
    prev_xfer = 1'b0;
    if (valid && rdy) begin
      prev_xfer = 1'b1;
      if (sb.size() == 0) chk("extra_sym", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sym", int'(num), e);
      end
    end
    @(negedge clk);
  endtask

  task automatic clr_stats();
    valid_cyc = 0;
    dones     = 0;
    done_ok   = 0;
    lat       = 0;
    prev_xfer = 1'b0;
  endtask

  // exp_valid / exp_lat < 0 skip that check (used when ready toggles).
  task automatic run_burst(input string tag, input int cnt, input int gp,
                           input bit toggle, input int mid_start_at,
                           input int exp_valid, input int exp_lat);
    clr_stats();
    push_burst(cnt, gp);
    start = 1'b1;
    count = CNT_W'(cnt);
    gap   = 2'(gp);
    tick(1'b1);
    start = 1'b0;
    chk({tag, "_first_busy"},  int'(busy),  1);
    chk({tag, "_first_valid"}, int'(valid), 1);
    chk({tag, "_first_num"},   int'(num),   1);
    for (int c = 0; c < 2000 && dones == 0; c++) begin
      if (c == mid_start_at) begin
        start = 1'b1;
        count = CNT_W'(5);
        gap   = 2'd3;
      end else begin
        start = 1'b0;
      end
      tick(toggle ? ((c % 2) == 0) : 1'b1);
      lat++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, dones, 1);
    chk({tag, "_done_after_last"}, done_ok, 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    if (exp_valid >= 0) chk({tag, "_valid_cycles"}, valid_cyc, exp_valid);
    if (exp_lat >= 0)   chk({tag, "_latency"}, lat, exp_lat);
    tick(1'b1);
    tick(1'b1);
    chk({tag, "_single_done"}, dones, 1);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    count = '0;
    gap   = 2'd0;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_num",   int'(num),   0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_done",  int'(done),  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single pattern, then three patterns with two idle zeros between.
    run_burst("c1g0", 1, 0, 1'b0, -1, 3, 4);
    run_burst("c3g2", 3, 2, 1'b0, -1, 13, 14);

    // Back-pressure: ready alternates, every symbol must be held not lost.
    run_burst("c2tog", 2, 0, 1'b1, -1, -1, -1);

    // Zero-length request: immediate done, no symbol, never busy.
    clr_stats();
    start = 1'b1;
    count = '0;
    gap   = 2'd1;
    tick(1'b1);
    start = 1'b0;
    chk("c0_done",  int'(done),  1);
    chk("c0_busy",  int'(busy),  0);
    chk("c0_valid", int'(valid), 0);
    repeat (4) tick(1'b1);
    chk("c0_no_valid", valid_cyc, 0);
    chk("c0_one_done", dones, 1);

    // A start pulsed mid-burst must be ignored.
    run_burst("mid", 2, 0, 1'b0, 2, 6, 7);

    // Reset while SYM2 is presented aborts the burst without done.
    clr_stats();
    push_burst(4, 0);
    start = 1'b1;
    count = CNT_W'(4);
    gap   = 2'd0;
    tick(1'b1);
    start = 1'b0;
    tick(1'b1);
    chk("abort_pre_num", int'(num), 2);
    rst_n = 1'b0;
    tick(1'b0);
    chk("abort_num",   int'(num),   0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_busy",  int'(busy),  0);
    chk("abort_done",  int'(done),  0);
    rst_n = 1'b1;
    sb.delete();
    dones = 0;
    repeat (4) tick(1'b1);
    chk("abort_no_done", dones, 0);
    chk("abort_no_valid", int'(valid), 0);
    run_burst("fresh", 1, 1, 1'b0, -1, 3, 4);

    // Largest burst the counter can hold.
    run_burst("c15", 15, 0, 1'b0, -1, 45, 46);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
